// File: rtl/hist_pkg.sv
// Shared types and defaults for the histogram high-count bank scheduler.
package hist_pkg;

    localparam int unsigned HIST_ADDR_W = 9;
    localparam int unsigned HIST_DATA_W = 16;
    localparam int unsigned HIST_DEPTH  = 512;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCapt,
        StPresent,
        StClear,
        StDone
    } sweep_state_t;

endpackage

// File: rtl/hist_sweep_fsm.sv
// Sweep engine: walks one bank word by word and hands each word to curve_calc.
// HIST_BANK_SCHED_CLR_EN adds a clear-on-read write-back state after each accepted word.
module hist_sweep_fsm
    import hist_pkg::*;
#(
    parameter int unsigned ADDR_W = HIST_ADDR_W,
    parameter int unsigned DATA_W = HIST_DATA_W,
    parameter int unsigned DEPTH  = HIST_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_clr,
    input  logic              i_bank,
    input  logic              i_ready,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_valid,
    output logic              o_done,
    output logic              o_busy,
    output logic              o_bank,
    output logic              o_cen,
    output logic              o_wen,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    sweep_state_t      r_state;
    logic              r_valid;
    logic              r_done;
    logic              r_busy;
    logic              r_bank;
    logic              r_cen;
    logic              r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_abort;

    // A restart or clear withdraws the presented word in the same cycle.
    assign w_abort = i_start | i_clr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_bank  <= 1'b0;
            r_cen   <= 1'b1;
            r_wen   <= 1'b1;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_clr) begin
                r_state <= StIdle;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_cen   <= 1'b1;
                r_wen   <= 1'b1;
            end else if (i_start) begin
                r_state <= StRead;
                r_addr  <= '0;
                r_bank  <= i_bank;
                r_valid <= 1'b0;
                r_busy  <= 1'b1;
                r_cen   <= 1'b0;
                r_wen   <= 1'b1;
            end else begin
                unique case (r_state)
                    StIdle: ;
                    StRead: begin
                        r_state <= StCapt;
                        r_cen   <= 1'b1;
                    end
                    StCapt: begin
                        r_data  <= i_rd_data;
                        r_valid <= 1'b1;
                        r_state <= StPresent;
                    end
                    StPresent: begin
                        if (i_ready) begin
                            r_valid <= 1'b0;
`ifdef HIST_BANK_SCHED_CLR_EN
                            r_state <= StClear;
                            r_cen   <= 1'b0;
                            r_wen   <= 1'b0;
`else
                            if (r_addr == LastAddr) begin
                                r_state <= StDone;
                                r_done  <= 1'b1;
                            end else begin
                                r_addr  <= r_addr + 1'b1;
                                r_state <= StRead;
                                r_cen   <= 1'b0;
                            end
`endif
                        end
                    end
`ifdef HIST_BANK_SCHED_CLR_EN
                    StClear: begin
                        r_wen <= 1'b1;
                        if (r_addr == LastAddr) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                            r_cen   <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= StRead;
                            r_cen   <= 1'b0;
                        end
                    end
`endif
                    StDone: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_valid = r_valid & ~w_abort;
    assign o_done  = r_done & ~w_abort;
    assign o_busy  = r_busy;
    assign o_bank  = r_bank;
    assign o_cen   = r_cen;
    assign o_wen   = r_wen;
    assign o_addr  = r_addr;
    assign o_data  = r_data;

endmodule

// File: rtl/hist_bank_sched.sv
// Ping-pong bank scheduler: routes hist_stat to its bank and sweeps the other one.
// Build with HIST_BANK_SCHED_CLR_EN to zero each word after curve_calc accepts it.
module hist_bank_sched
    import hist_pkg::*;
#(
    parameter int unsigned ADDR_W = HIST_ADDR_W,
    parameter int unsigned DATA_W = HIST_DATA_W,
    parameter int unsigned DEPTH  = HIST_DEPTH
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic              clr_i,
    input  logic              mem_toggle_i,
    input  logic              hist_cen_i,
    input  logic              hist_wen_i,
    input  logic [ADDR_W-1:0] hist_addr_i,
    input  logic [DATA_W-1:0] hist_data_wr_i,
    output logic [DATA_W-1:0] hist_data_rd_o,
    output logic              bank0_cen_o,
    output logic              bank0_wen_o,
    output logic [ADDR_W-1:0] bank0_addr_o,
    output logic [DATA_W-1:0] bank0_data_wr_o,
    input  logic [DATA_W-1:0] bank0_data_rd_i,
    output logic              bank1_cen_o,
    output logic              bank1_wen_o,
    output logic [ADDR_W-1:0] bank1_addr_o,
    output logic [DATA_W-1:0] bank1_data_wr_o,
    input  logic [DATA_W-1:0] bank1_data_rd_i,
    output logic              curve_valid_o,
    input  logic              curve_ready_i,
    output logic [ADDR_W-1:0] curve_addr_o,
    output logic              curve_bank_o,
    output logic [DATA_W-1:0] curve_data_o,
    output logic              curve_done_o,
    output logic              sweep_busy_o,
    output logic              overrun_o
);

    logic              r_tog_q;
    logic              r_rd_sel;
    logic              r_overrun;
    logic              w_edge;
    logic              w_start;
    logic              w_busy;
    logic              w_sw_bank;
    logic              w_sw_cen;
    logic              w_sw_wen;
    logic [ADDR_W-1:0] w_sw_addr;
    logic [DATA_W-1:0] w_sw_rd;

    assign w_edge  = enable_i & (mem_toggle_i ^ r_tog_q);
    assign w_start = w_edge & ~clr_i;
    assign w_sw_rd = w_sw_bank ? bank1_data_rd_i : bank0_data_rd_i;

    always_ff @(posedge pclk) begin
        r_tog_q <= mem_toggle_i;
        if (rst) begin
            r_rd_sel  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_rd_sel <= mem_toggle_i;
            if (clr_i) begin
                r_overrun <= 1'b0;
            end else if (w_edge && w_busy) begin
                r_overrun <= 1'b1;
            end
        end
    end

    hist_sweep_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_sweep (
        .i_clk     (pclk),
        .i_rst     (rst),
        .i_start   (w_start),
        .i_clr     (clr_i),
        .i_bank    (r_tog_q),
        .i_ready   (curve_ready_i),
        .i_rd_data (w_sw_rd),
        .o_valid   (curve_valid_o),
        .o_done    (curve_done_o),
        .o_busy    (w_busy),
        .o_bank    (w_sw_bank),
        .o_cen     (w_sw_cen),
        .o_wen     (w_sw_wen),
        .o_addr    (w_sw_addr),
        .o_data    (curve_data_o)
    );

    // A bank only sees sweep traffic when it is the latched sweep bank and not owned by hist_stat.
    always_comb begin
        bank0_cen_o     = 1'b1;
        bank0_wen_o     = 1'b1;
        bank0_addr_o    = w_sw_addr;
        bank0_data_wr_o = '0;
        bank1_cen_o     = 1'b1;
        bank1_wen_o     = 1'b1;
        bank1_addr_o    = w_sw_addr;
        bank1_data_wr_o = '0;
        hist_data_rd_o  = r_rd_sel ? bank1_data_rd_i : bank0_data_rd_i;
        if (rst) begin
            bank0_addr_o   = '0;
            bank1_addr_o   = '0;
            hist_data_rd_o = '0;
        end else begin
            if (!mem_toggle_i) begin
                bank0_cen_o     = hist_cen_i;
                bank0_wen_o     = hist_wen_i;
                bank0_addr_o    = hist_addr_i;
                bank0_data_wr_o = hist_data_wr_i;
            end else if (!w_sw_bank) begin
                bank0_cen_o = w_sw_cen;
                bank0_wen_o = w_sw_wen;
            end
            if (mem_toggle_i) begin
                bank1_cen_o     = hist_cen_i;
                bank1_wen_o     = hist_wen_i;
                bank1_addr_o    = hist_addr_i;
                bank1_data_wr_o = hist_data_wr_i;
            end else if (w_sw_bank) begin
                bank1_cen_o = w_sw_cen;
                bank1_wen_o = w_sw_wen;
            end
        end
    end

    assign curve_addr_o = w_sw_addr;
    assign curve_bank_o = w_sw_bank;
    assign sweep_busy_o = w_busy;
    assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_hist_bank_sched.sv
// Bench for hist_bank_sched: two SRAM models, randomized data and ready, word-order reference.
module tb_hist_bank_sched;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 512;
`ifdef HIST_BANK_SCHED_CLR_EN
    localparam bit ClrEn = 1'b1;
`else
    localparam bit ClrEn = 1'b0;
`endif
    // Cycles per word with ready held high: read, capture, present (+ clear write-back).
    localparam int WordCycles = ClrEn ? 4 : 3;

    logic          pclk = 1'b0;
    logic          rst;
    logic          enable_i, clr_i, mem_toggle_i;
    logic          hist_cen_i, hist_wen_i;
    logic [AW-1:0] hist_addr_i;
    logic [DW-1:0] hist_data_wr_i, hist_data_rd_o;
    logic          bank0_cen_o, bank0_wen_o, bank1_cen_o, bank1_wen_o;
    logic [AW-1:0] bank0_addr_o, bank1_addr_o;
    logic [DW-1:0] bank0_data_wr_o, bank1_data_wr_o, bank0_data_rd_i, bank1_data_rd_i;
    logic          curve_valid_o, curve_ready_i, curve_bank_o, curve_done_o;
    logic [AW-1:0] curve_addr_o;
    logic [DW-1:0] curve_data_o;
    logic          sweep_busy_o, overrun_o;

    hist_bank_sched #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .pclk            (pclk),
        .rst             (rst),
        .enable_i        (enable_i),
        .clr_i           (clr_i),
        .mem_toggle_i    (mem_toggle_i),
        .hist_cen_i      (hist_cen_i),
        .hist_wen_i      (hist_wen_i),
        .hist_addr_i     (hist_addr_i),
        .hist_data_wr_i  (hist_data_wr_i),
        .hist_data_rd_o  (hist_data_rd_o),
        .bank0_cen_o     (bank0_cen_o),
        .bank0_wen_o     (bank0_wen_o),
        .bank0_addr_o    (bank0_addr_o),
        .bank0_data_wr_o (bank0_data_wr_o),
        .bank0_data_rd_i (bank0_data_rd_i),
        .bank1_cen_o     (bank1_cen_o),
        .bank1_wen_o     (bank1_wen_o),
        .bank1_addr_o    (bank1_addr_o),
        .bank1_data_wr_o (bank1_data_wr_o),
        .bank1_data_rd_i (bank1_data_rd_i),
        .curve_valid_o   (curve_valid_o),
        .curve_ready_i   (curve_ready_i),
        .curve_addr_o    (curve_addr_o),
        .curve_bank_o    (curve_bank_o),
        .curve_data_o    (curve_data_o),
        .curve_done_o    (curve_done_o),
        .sweep_busy_o    (sweep_busy_o),
        .overrun_o       (overrun_o)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // Single-port SRAM models; fillN copies the bench reference image into the bank.
    logic [DW-1:0] sram0 [DEPTH];
    logic [DW-1:0] sram1 [DEPTH];
    logic [DW-1:0] ref0  [DEPTH];
    logic [DW-1:0] ref1  [DEPTH];
    logic          fill0 = 1'b0, fill1 = 1'b0;
    logic [DW-1:0] rd0 = '0, rd1 = '0;

    always @(posedge pclk) begin
        if (fill0) begin
            for (int i = 0; i < DEPTH; i++) sram0[i] <= ref0[i];
        end else if (!bank0_cen_o) begin
            if (!bank0_wen_o) sram0[bank0_addr_o] <= bank0_data_wr_o;
            else rd0 <= sram0[bank0_addr_o];
        end
        if (fill1) begin
            for (int i = 0; i < DEPTH; i++) sram1[i] <= ref1[i];
        end else if (!bank1_cen_o) begin
            if (!bank1_wen_o) sram1[bank1_addr_o] <= bank1_data_wr_o;
            else rd1 <= sram1[bank1_addr_o];
        end
    end
    assign bank0_data_rd_i = rd0;
    assign bank1_data_rd_i = rd1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state: next expected word of the current sweep.
    bit            mon_en = 1'b0;
    bit            skip_stab = 1'b0;
    int            exp_addr = 0;
    bit            exp_bank = 1'b0;
    int            n_done = 0;
    int            done_cyc = -1;
    int            first_valid_cyc = -1;
    logic          p_valid = 1'b0, p_ready = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_data = '0;

    task automatic mon();
        if (mon_en) begin
            if (p_valid && !p_ready && !skip_stab) begin
                check_eq("stall_valid", 32'(curve_valid_o), 32'd1);
                check_eq("stall_addr", 32'(curve_addr_o), 32'(p_addr));
                check_eq("stall_data", 32'(curve_data_o), 32'(p_data));
            end
            if (curve_valid_o && !curve_ready_i)
                check_eq("stall_no_access", 32'(curve_bank_o ? bank1_cen_o : bank0_cen_o), 32'd1);
            if (curve_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (curve_valid_o && curve_ready_i) begin
                check_eq("word_addr", 32'(curve_addr_o), 32'(exp_addr));
                check_eq("word_bank", 32'(curve_bank_o), 32'(exp_bank));
                check_eq("word_data", 32'(curve_data_o),
                         32'(exp_bank ? ref1[exp_addr] : ref0[exp_addr]));
                exp_addr++;
            end
            if (curve_done_o) begin
                n_done++;
                done_cyc = cyc;
            end
        end
        p_valid = curve_valid_o;
        p_ready = curve_ready_i;
        p_addr  = curve_addr_o;
        p_data  = curve_data_o;
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic sample();
        @(negedge pclk);
        mon();
    endtask

    task automatic adv();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            sample();
            adv();
        end
    endtask

    int            t_edge;
    int            stall_cnt;
    int            bad;
    bit            hit;
    logic [DW-1:0] w7;

    initial begin
        rst = 1'b1; enable_i = 1'b1; clr_i = 1'b0; mem_toggle_i = 1'b1;
        hist_cen_i = 1'b0; hist_wen_i = 1'b1; hist_addr_i = 9'd7; hist_data_wr_i = '0;
        curve_ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ref0[i] = DW'($urandom);
            ref1[i] = DW'($urandom);
        end
        ref0[5] = 16'h0A03;
        fill0 = 1'b1; fill1 = 1'b1;
        adv();
        fill0 = 1'b0; fill1 = 1'b0;

        // Reset: hist_stat requests are blocked and outputs sit at reset values.
        sample();
        check_eq("rst_b0_cen", 32'(bank0_cen_o), 32'd1);
        check_eq("rst_b1_cen", 32'(bank1_cen_o), 32'd1);
        check_eq("rst_b1_addr", 32'(bank1_addr_o), 32'd0);
        check_eq("rst_hist_rd", 32'(hist_data_rd_o), 32'd0);
        adv();
        rst = 1'b0; hist_cen_i = 1'b1;
        idle(3);
        sample();
        check_eq("post_rst_busy", 32'(sweep_busy_o), 32'd0);
        check_eq("post_rst_valid", 32'(curve_valid_o), 32'd0);
        check_eq("post_rst_done", 32'(curve_done_o), 32'd0);
        check_eq("post_rst_ovr", 32'(overrun_o), 32'd0);
        check_eq("post_rst_bank", 32'(curve_bank_o), 32'd0);
        check_eq("post_rst_addr", 32'(curve_addr_o), 32'd0);
        check_eq("post_rst_data", 32'(curve_data_o), 32'd0);
        adv();

        // hist write passes straight through to bank1.
        w7 = DW'($urandom);
        hist_cen_i = 1'b0; hist_wen_i = 1'b0; hist_addr_i = 9'd7; hist_data_wr_i = w7;
        sample();
        check_eq("hist_b1_cen", 32'(bank1_cen_o), 32'd0);
        check_eq("hist_b1_wen", 32'(bank1_wen_o), 32'd0);
        check_eq("hist_b1_addr", 32'(bank1_addr_o), 32'd7);
        check_eq("hist_b1_data", 32'(bank1_data_wr_o), 32'(w7));
        check_eq("hist_b0_idle", 32'(bank0_cen_o), 32'd1);
        adv();
        hist_cen_i = 1'b1; hist_wen_i = 1'b1;
        ref1[7] = w7;

        // Toggle while disabled is ignored.
        enable_i = 1'b0; mem_toggle_i = 1'b0;
        idle(3);
        sample();
        check_eq("disabled_no_sweep", 32'(sweep_busy_o), 32'd0);
        adv();
        enable_i = 1'b1;
        idle(2);
        sample();
        check_eq("enable_no_false_edge", 32'(sweep_busy_o), 32'd0);
        adv();

        // Sweep A: bank0, ready held high.
        mon_en = 1'b1;
        mem_toggle_i = 1'b1; curve_ready_i = 1'b1;
        exp_addr = 0; exp_bank = 1'b0; first_valid_cyc = -1; n_done = 0;
        t_edge = cyc;
        for (int c = 0; c < 3000 && n_done == 0; c++) begin
            sample();
            adv();
        end
        check_eq("a_done_count", 32'(n_done), 32'd1);
        check_eq("a_done_latency", 32'(done_cyc - t_edge), 32'(WordCycles * DEPTH + 1));
        check_eq("a_first_valid", 32'(first_valid_cyc - t_edge), 32'd3);
        check_eq("a_words", 32'(exp_addr), 32'(DEPTH));
        sample();
        check_eq("a_idle_after", 32'(sweep_busy_o), 32'd0);
        adv();
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sram0[i] !== (ClrEn ? 16'h0000 : ref0[i])) bad++;
            if (sram1[i] !== ref1[i]) bad++;
        end
        check_eq("a_bank_contents", 32'(bad), 32'd0);

        // Sweep B: bank1 with random ready, 10-cycle stall at addr 3, overrun at addr 100.
        for (int i = 0; i < DEPTH; i++) ref0[i] = DW'($urandom);
        fill0 = 1'b1;
        sample();
        check_eq("b_ovr_before", 32'(overrun_o), 32'd0);
        adv();
        fill0 = 1'b0;
        mem_toggle_i = 1'b0;
        exp_addr = 0; exp_bank = 1'b1;
        stall_cnt = 0; hit = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (curve_addr_o == 9'd3 && stall_cnt < 10) begin
                curve_ready_i = 1'b0;
                if (curve_valid_o) stall_cnt++;
            end else if (curve_addr_o >= 9'd100) begin
                curve_ready_i = 1'b0;
            end else begin
                curve_ready_i = 1'($urandom_range(0, 1));
            end
            sample();
            if (curve_valid_o && curve_addr_o == 9'd100) begin
                hit = 1'b1;
                adv();
                break;
            end
            adv();
        end
        check_eq("b_reach_100", 32'(hit), 32'd1);
        check_eq("b_stall_cycles", 32'(stall_cnt), 32'd10);
        check_eq("b_accepted", 32'(exp_addr), 32'd100);
        mem_toggle_i = 1'b1; curve_ready_i = 1'b0; skip_stab = 1'b1;
        sample();
        check_eq("ovr_valid_drop", 32'(curve_valid_o), 32'd0);
        check_eq("ovr_no_done", 32'(curve_done_o), 32'd0);
        adv();
        skip_stab = 1'b0;
        exp_addr = 0; exp_bank = 1'b0;
        sample();
        check_eq("ovr_set", 32'(overrun_o), 32'd1);
        check_eq("ovr_busy", 32'(sweep_busy_o), 32'd1);
        check_eq("ovr_bank", 32'(curve_bank_o), 32'd0);
        check_eq("ovr_addr", 32'(curve_addr_o), 32'd0);
        adv();
        for (int c = 0; c < 8000 && n_done < 2; c++) begin
            curve_ready_i = ($urandom_range(0, 3) != 0);
            sample();
            adv();
        end
        check_eq("b_done_count", 32'(n_done), 32'd2);
        check_eq("b_words", 32'(exp_addr), 32'(DEPTH));
        sample();
        check_eq("ovr_sticky", 32'(overrun_o), 32'd1);
        adv();
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sram0[i] !== (ClrEn ? 16'h0000 : ref0[i])) bad++;
            if (sram1[i] !== ((ClrEn && i < 100) ? 16'h0000 : ref1[i])) bad++;
        end
        check_eq("b_bank_contents", 32'(bad), 32'd0);

        // clr_i wins over a toggle edge in the same cycle.
        mem_toggle_i = 1'b0; clr_i = 1'b1; curve_ready_i = 1'b0; skip_stab = 1'b1;
        sample();
        check_eq("clr_valid", 32'(curve_valid_o), 32'd0);
        adv();
        clr_i = 1'b0;
        sample();
        check_eq("clr_idle", 32'(sweep_busy_o), 32'd0);
        check_eq("clr_ovr", 32'(overrun_o), 32'd0);
        adv();
        skip_stab = 1'b0;
        idle(3);
        sample();
        check_eq("clr_no_late_sweep", 32'(sweep_busy_o), 32'd0);
        adv();

        // hist read on bank1 in the toggle-edge cycle returns bank1 data next cycle.
        mon_en = 1'b0;
        ref1[7] = DW'($urandom);
        fill1 = 1'b1;
        sample();
        adv();
        fill1 = 1'b0;
        mem_toggle_i = 1'b1; hist_cen_i = 1'b0; hist_wen_i = 1'b1; hist_addr_i = 9'd7;
        sample();
        check_eq("hrd_b1_cen", 32'(bank1_cen_o), 32'd0);
        check_eq("hrd_b1_addr", 32'(bank1_addr_o), 32'd7);
        adv();
        hist_cen_i = 1'b1;
        sample();
        check_eq("hrd_data", 32'(hist_data_rd_o), 32'(ref1[7]));
        check_eq("hrd_sweep_started", 32'(sweep_busy_o), 32'd1);
        adv();
        clr_i = 1'b1;
        sample();
        adv();
        clr_i = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
